// File: rtl/btb_update_ctrl.sv
// BTB update scheduler: two branch-resolution sources into one in-order FIFO, drained
// one entry per cycle to the BTB update port. Optional filter: define BTB_UPD_FILTER_EN.
module btb_update_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br0_valid,
  output logic             br0_ready,
  input  logic [31:0]      br0_pc,
  input  logic [31:0]      br0_target,
  input  logic             br0_taken,
  input  logic             br0_pred_taken,
  input  logic             br1_valid,
  output logic             br1_ready,
  input  logic [31:0]      br1_pc,
  input  logic [31:0]      br1_target,
  input  logic             br1_taken,
  input  logic             br1_pred_taken,
  input  logic             upd_stall,
  output logic             update_en,
  output logic [31:0]      update_pc,
  output logic [31:0]      update_target,
  output logic             actual_taken,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [15:0]      filt_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        taken;
  } ent_t;

  ent_t          mem_q [DEPTH];
  ent_t          mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d, free;
  logic          rr_q, rr_d;
  logic          upd_en_q, upd_en_d, act_taken_q, act_taken_d;
  logic [31:0]   upd_pc_q, upd_pc_d, upd_tgt_q, upd_tgt_d;
  logic          filt0, filt1, need0, need1, acc0, acc1, pop;
  logic          free_ge2, free_eq1, contend;
  ent_t          ent0, ent1, head;

`ifdef BTB_UPD_FILTER_EN
  logic [15:0] filt_cnt_q, filt_cnt_d;
  logic [16:0] filt_sum;

  assign filt0 = br0_valid & ~br0_taken & ~br0_pred_taken;
  assign filt1 = br1_valid & ~br1_taken & ~br1_pred_taken;

  always_comb begin
    filt_sum   = {1'b0, filt_cnt_q} + 17'(filt0) + 17'(filt1);
    filt_cnt_d = filt_sum[16] ? 16'hFFFF : filt_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) filt_cnt_q <= '0;
    else     filt_cnt_q <= filt_cnt_d;
  end

  assign filt_cnt = filt_cnt_q;
`else
  logic unused_pred;
  assign unused_pred = br0_pred_taken ^ br1_pred_taken;
  assign filt0       = 1'b0;
  assign filt1       = 1'b0;
  assign filt_cnt    = '0;
`endif

  assign need0 = br0_valid & ~filt0;
  assign need1 = br1_valid & ~filt1;

  // free counts registered occupancy only, so a same-cycle pop never frees a slot
  assign free     = CW'(DEPTH) - occ_q;
  assign free_ge2 = free >= CW'(2);
  assign free_eq1 = free == CW'(1);
  assign contend  = free_eq1 & need0 & need1;

  assign br0_ready = filt0 | free_ge2 | (free_eq1 & (~contend | ~rr_q));
  assign br1_ready = filt1 | free_ge2 | (free_eq1 & (~contend |  rr_q));

  assign acc0 = need0 & br0_ready;
  assign acc1 = need1 & br1_ready;
  assign pop  = (occ_q != '0) & ~upd_stall;

  assign ent0 = '{pc: br0_pc, tgt: br0_target, taken: br0_taken};
  assign ent1 = '{pc: br1_pc, tgt: br1_target, taken: br1_taken};
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    mem_d = mem_q;
    if (acc0) mem_d[wr_ptr_q] = ent0;
    if (acc1) mem_d[acc0 ? wr_ptr_q + PW'(1) : wr_ptr_q] = ent1;
    wr_ptr_d = wr_ptr_q + PW'(acc0) + PW'(acc1);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    occ_d    = occ_q + CW'(acc0) + CW'(acc1) - CW'(pop);
    rr_d     = rr_q ^ contend;
  end

  always_comb begin
    upd_en_d    = pop;
    upd_pc_d    = pop ? head.pc    : upd_pc_q;
    upd_tgt_d   = pop ? head.tgt   : upd_tgt_q;
    act_taken_d = pop ? head.taken : act_taken_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      rr_q        <= 1'b0;
      upd_en_q    <= 1'b0;
      upd_pc_q    <= '0;
      upd_tgt_q   <= '0;
      act_taken_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      rr_q        <= rr_d;
      upd_en_q    <= upd_en_d;
      upd_pc_q    <= upd_pc_d;
      upd_tgt_q   <= upd_tgt_d;
      act_taken_q <= act_taken_d;
    end
  end

  assign update_en     = upd_en_q;
  assign update_pc     = upd_pc_q;
  assign update_target = upd_tgt_q;
  assign actual_taken  = act_taken_q;
  assign occupancy     = occ_q;
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: a cycle model predicts readies, occupancy and
// drain timing; accepted requests are queued and matched against update_en payloads.
module tb_btb_update_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        br0_valid, br0_ready, br0_taken, br0_pred_taken;
  logic        br1_valid, br1_ready, br1_taken, br1_pred_taken;
  logic [31:0] br0_pc, br0_target, br1_pc, br1_target;
  logic        upd_stall, update_en, actual_taken;
  logic [31:0] update_pc, update_target;
  logic [2:0]  occupancy;
  logic [15:0] filt_cnt;

  always #5 clk = ~clk;

  btb_update_ctrl #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .br0_valid(br0_valid), .br0_ready(br0_ready), .br0_pc(br0_pc), .br0_target(br0_target),
    .br0_taken(br0_taken), .br0_pred_taken(br0_pred_taken),
    .br1_valid(br1_valid), .br1_ready(br1_ready), .br1_pc(br1_pc), .br1_target(br1_target),
    .br1_taken(br1_taken), .br1_pred_taken(br1_pred_taken),
    .upd_stall(upd_stall), .update_en(update_en), .update_pc(update_pc),
    .update_target(update_target), .actual_taken(actual_taken),
    .occupancy(occupancy), .filt_cnt(filt_cnt)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  int   m_occ, m_filt;
  bit   m_rr;
  logic seen_r0, seen_r1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int u, input bit v, input logic [31:0] pc, input logic [31:0] tgt,
                       input bit tk, input bit ptk);
    if (u == 0) begin
      br0_valid = v; br0_pc = pc; br0_target = tgt; br0_taken = tk; br0_pred_taken = ptk;
    end else begin
      br1_valid = v; br1_pc = pc; br1_target = tgt; br1_taken = tk; br1_pred_taken = ptk;
    end
  endtask

  task automatic idle();
    br0_valid = 1'b0;
    br1_valid = 1'b0;
  endtask

  // Called just after a falling edge with inputs set; returns at the next falling edge.
  task automatic step();
    bit   f0, f1, n0, n1, r0, r1, a0, a1, pop;
    int   free;
    exp_t e;
    #1;
    f0 = 1'b0;
    f1 = 1'b0;
`ifdef BTB_UPD_FILTER_EN
    f0 = br0_valid & ~br0_taken & ~br0_pred_taken;
    f1 = br1_valid & ~br1_taken & ~br1_pred_taken;
`endif
    n0 = br0_valid & ~f0;
    n1 = br1_valid & ~f1;
    chk("occupancy", occupancy, m_occ);
    chk("filt_cnt", filt_cnt, m_filt);
    free = 4 - m_occ;
    if (free >= 2) begin
      r0 = 1; r1 = 1;
    end else if (free == 1) begin
      if (n0 && n1) begin
        r0 = (m_rr == 0); r1 = (m_rr == 1);
        m_rr = ~m_rr;
      end else begin
        r0 = 1; r1 = 1;
      end
    end else begin
      r0 = f0; r1 = f1;
    end
    seen_r0 = br0_ready;
    seen_r1 = br1_ready;
    if (br0_valid) chk("br0_ready", br0_ready, r0);
    if (br1_valid) chk("br1_ready", br1_ready, r1);
    a0 = n0 & r0;
    a1 = n1 & r1;
    if (a0) sbq.push_back('{pc: br0_pc, tgt: br0_target, tk: br0_taken});
    if (a1) sbq.push_back('{pc: br1_pc, tgt: br1_target, tk: br1_taken});
    m_filt = m_filt + f0 + f1;
    if (m_filt > 65535) m_filt = 65535;
    pop   = (m_occ > 0) && !upd_stall;
    m_occ = m_occ + a0 + a1 - pop;
    @(posedge clk);
    #1;
    chk("update_en", update_en, pop);
    if (update_en) begin
      chk("sb_nonempty", sbq.size() != 0, 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("update_pc", update_pc, e.pc);
        chk("update_target", update_target, e.tgt);
        chk("actual_taken", actual_taken, e.tk);
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    idle();
    upd_stall = 1'b0;
    repeat (7) step();
    chk("sb_drained", sbq.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    upd_stall = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    m_occ = 0; m_filt = 0; m_rr = 0;
    repeat (2) @(negedge clk);
    chk("rst_update_en", update_en, 0);
    chk("rst_update_pc", update_pc, 0);
    chk("rst_update_target", update_target, 0);
    chk("rst_actual_taken", actual_taken, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_filt_cnt", filt_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // single request: update_en two cycles after acceptance
    drive(0, 1, 32'h100, 32'h200, 1, 1);
    step();
    chk("lat_en_n1", update_en, 0);
    idle();
    step();
    chk("lat_en_n2", update_en, 1);
    chk("lat_pc", update_pc, 32'h100);
    chk("lat_tgt", update_target, 32'h200);
    drain();

    // both units on an empty FIFO: br0 drains first
    drive(0, 1, 32'h1000, 32'h1100, 1, 0);
    drive(1, 1, 32'h2000, 32'h2200, 0, 1);
    step();
    chk("both_r0", seen_r0, 1);
    chk("both_r1", seen_r1, 1);
    idle();
    step();
    chk("both_first_pc", update_pc, 32'h1000);
    step();
    chk("both_second_pc", update_pc, 32'h2000);
    drain();

    // fill under stall, then full+pop with requests present, then release
    upd_stall = 1'b1;
    drive(0, 1, 32'h3000, 32'h3004, 1, 1);
    drive(1, 1, 32'h3010, 32'h3014, 0, 0);
    step();
    drive(0, 1, 32'h3020, 32'h3024, 1, 0);
    drive(1, 1, 32'h3030, 32'h3034, 1, 1);
    step();
    chk("full_occ", occupancy, 4);
    drive(0, 1, 32'h3040, 32'h3044, 1, 1);
    drive(1, 1, 32'h3050, 32'h3054, 1, 1);
    step();
    chk("full_r0", seen_r0, 0);
    chk("full_r1", seen_r1, 0);
    upd_stall = 1'b0;
    step();
    chk("fullpop_r0", seen_r0, 0);
    chk("fullpop_r1", seen_r1, 0);
    drain();

    // occupancy held at 3 with both requesting: grants alternate
    upd_stall = 1'b1;
    drive(0, 1, 32'h4000, 32'h4004, 1, 1);
    drive(1, 1, 32'h4010, 32'h4014, 1, 1);
    step();
    idle();
    drive(0, 1, 32'h4020, 32'h4024, 0, 1);
    step();
    upd_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 32'h5000 + 32'(i * 16), 32'h5800, 1, 1);
      drive(1, 1, 32'h6000 + 32'(i * 16), 32'h6800, 1, 1);
      step();
      chk("rr_grant0", seen_r0, (i % 2) == 0);
      chk("rr_grant1", seen_r1, (i % 2) == 1);
    end
    drain();

`ifdef BTB_UPD_FILTER_EN
    upd_stall = 1'b1;
    drive(0, 1, 32'h7000, 32'h7004, 1, 1);
    drive(1, 1, 32'h7010, 32'h7014, 1, 0);
    step();
    step();
    idle();
    drive(0, 1, 32'h7100, 32'h7104, 0, 0);
    step();
    chk("filt_ready", seen_r0, 1);
    chk("filt_cnt_one", filt_cnt, 1);
    chk("filt_occ", occupancy, 4);
    drain();
`endif

    for (int i = 0; i < 250; i++) begin
      upd_stall = ($urandom_range(0, 9) < 3);
      drive(0, $urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, 1), $urandom_range(0, 1));
      drive(1, $urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, 1), $urandom_range(0, 1));
      step();
    end
    drain();

    // reset with three entries queued
    upd_stall = 1'b1;
    drive(0, 1, 32'h8000, 32'h8004, 1, 1);
    drive(1, 1, 32'h8010, 32'h8014, 1, 1);
    step();
    idle();
    drive(0, 1, 32'h8020, 32'h8024, 1, 1);
    step();
    idle();
    chk("pre_rst_occ", occupancy, 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_update_en", update_en, 0);
    chk("mid_rst_update_pc", update_pc, 0);
    chk("mid_rst_update_target", update_target, 0);
    chk("mid_rst_actual_taken", actual_taken, 0);
    chk("mid_rst_occupancy", occupancy, 0);
    @(negedge clk);
    rst = 1'b0;
    upd_stall = 1'b0;
    m_occ = 0; m_filt = 0; m_rr = 0;
    sbq.delete();
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
